pipe_scoreboard: RTL and testbench



---
 rtl/pipe_pkg.sv | 15 +
 rtl/sb_reg_entry.sv | 33 +++
 rtl/pipe_scoreboard.sv | 72 +++++++
 tb/tb_pipe_scoreboard.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: scoreboard defaults, forwarding encoding and derived-width helpers
package pipe_pkg;
    localparam int NREG_DEFAULT   = 32;
    localparam int MAXLAT_DEFAULT = 4;
    localparam int FWD_REGFILE    = 0;
    function automatic int lat_w(input int maxlat);
        return $clog2(maxlat + 1);
    endfunction
    function automatic int idx_w(input int nreg);
        return $clog2(nreg);
    endfunction
    function automatic int cnt_w(input int nreg);
        return $clog2(nreg + 1);
    endfunction
endpackage

// File: rtl/sb_reg_entry.sv
// sb_reg_entry: writeback and bypass countdown for one architectural register
module sb_reg_entry #(
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          load,
    input  logic [LW-1:0] lat,
    input  logic [LW-1:0] byp,
    output logic [LW-1:0] wb_cnt,
    output logic          busy,
    output logic          byp_busy,
    output logic          busy_nxt
);
    logic [LW-1:0] bp_cnt, wb_nxt, bp_nxt;
    always_comb begin
        wb_nxt = flush ? '0 : load ? lat : wb_cnt - LW'(wb_cnt != '0);
        bp_nxt = flush ? '0 : load ? byp : bp_cnt - LW'(bp_cnt != '0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_cnt <= '0;
            bp_cnt <= '0;
        end else begin
            wb_cnt <= wb_nxt;
            bp_cnt <= bp_nxt;
        end
    end
    assign busy     = wb_cnt != '0;
    assign byp_busy = bp_cnt != '0;
    assign busy_nxt = wb_nxt != '0;
endmodule

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: RAW/WAW issue interlock with per-source bypass stage selection
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG   = NREG_DEFAULT,
    parameter int NSRC   = 2,
    parameter int MAXLAT = MAXLAT_DEFAULT,
    parameter int LW     = lat_w(MAXLAT),
    parameter int AW     = idx_w(NREG)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [NSRC*AW-1:0]       issue_src,
    input  logic [NSRC-1:0]          issue_src_en,
    input  logic                     issue_wen,
    input  logic [AW-1:0]            issue_dst,
    input  logic [LW-1:0]            issue_lat,
    input  logic [LW-1:0]            issue_byp,
    input  logic                     flush,
    output logic [NSRC*LW-1:0]       fwd_sel,
    output logic [cnt_w(NREG)-1:0]   pending
);
    localparam int PW = cnt_w(NREG);
    logic [LW-1:0]   wb_cnt [NREG];
    logic [NREG-1:0] busy, byp_busy, busy_nxt;
    logic            eff_wen, raw, waw, accept;
    logic [PW-1:0]   pend_nxt;
    assign wb_cnt[0]   = '0;
    assign busy[0]     = 1'b0;
    assign byp_busy[0] = 1'b0;
    assign busy_nxt[0] = 1'b0;
    // malformed latency pairs behave as a non-writing instruction
    assign eff_wen     = issue_wen && issue_dst != '0 && issue_lat != '0 && issue_byp <= issue_lat;
    assign waw         = eff_wen && wb_cnt[issue_dst] > issue_lat;
    assign issue_ready = !flush && !raw && !waw;
    assign accept      = issue_valid && issue_ready && eff_wen;
    for (genvar r = 1; r < NREG; r++) begin : g_ent
        sb_reg_entry #(.LW(LW)) u_ent (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .load     (accept && issue_dst == AW'(r)),
            .lat      (issue_lat),
            .byp      (issue_byp),
            .wb_cnt   (wb_cnt[r]),
            .busy     (busy[r]),
            .byp_busy (byp_busy[r]),
            .busy_nxt (busy_nxt[r])
        );
    end
    always_comb begin
        raw     = 1'b0;
        fwd_sel = {NSRC{LW'(FWD_REGFILE)}};
        for (int s = 0; s < NSRC; s++) begin
            if (issue_src_en[s] && issue_src[s*AW +: AW] != '0) begin
                raw = raw | byp_busy[issue_src[s*AW +: AW]];
                if (busy[issue_src[s*AW +: AW]] && !byp_busy[issue_src[s*AW +: AW]])
                    fwd_sel[s*LW +: LW] = wb_cnt[issue_src[s*AW +: AW]];
            end
        end
    end
    always_comb begin
        pend_nxt = '0;
        for (int i = 0; i < NREG; i++) pend_nxt = pend_nxt + PW'(busy_nxt[i]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else pending <= pend_nxt;
    end
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed scenarios plus random traffic against a per-register countdown model
module tb_pipe_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid, issue_ready, issue_wen, flush;
    logic [9:0] issue_src;
    logic [1:0] issue_src_en;
    logic [4:0] issue_dst;
    logic [2:0] issue_lat, issue_byp;
    logic [5:0] fwd_sel;
    logic [5:0] pending;

    logic       v, wen, fl;
    logic [4:0] dst;
    logic [2:0] lat, byp;
    logic [4:0] src [2];
    logic       en  [2];

    int wb_m [32];
    int bp_m [32];
    int tests = 0, fails = 0;
    int r_ready, r_fwd0, r_fwd1, r_pend;

    pipe_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_src    (issue_src),
        .issue_src_en (issue_src_en),
        .issue_wen    (issue_wen),
        .issue_dst    (issue_dst),
        .issue_lat    (issue_lat),
        .issue_byp    (issue_byp),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    always_comb begin
        issue_valid  = v;
        issue_wen    = wen;
        issue_dst    = dst;
        issue_lat    = lat;
        issue_byp    = byp;
        flush        = fl;
        issue_src    = {src[1], src[0]};
        issue_src_en = {en[1], en[0]};
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        v = 0; wen = 0; fl = 0; dst = 0; lat = 0; byp = 0;
        src[0] = 0; src[1] = 0; en[0] = 0; en[1] = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            wb_m[i] = 0;
            bp_m[i] = 0;
        end
    endtask

    function automatic bit writes();
        return wen && dst != 0 && lat != 0 && byp <= lat;
    endfunction

    function automatic bit m_ready();
        bit hz = fl;
        for (int s = 0; s < 2; s++)
            if (en[s] && src[s] != 0 && bp_m[src[s]] != 0) hz = 1;
        if (writes() && wb_m[dst] > int'(lat)) hz = 1;
        return !hz;
    endfunction

    function automatic int m_fwd(input int s);
        if (!en[s] || src[s] == 0) return 0;
        return (wb_m[src[s]] != 0 && bp_m[src[s]] == 0) ? wb_m[src[s]] : 0;
    endfunction

    function automatic int m_pend();
        int n = 0;
        for (int i = 1; i < 32; i++) if (wb_m[i] != 0) n++;
        return n;
    endfunction

    // one clock cycle: compare at the falling edge, then advance the model at the rising edge
    task automatic step();
        bit rdy;
        @(negedge clk);
        rdy = m_ready();
        r_ready = int'(issue_ready);
        r_fwd0  = int'(fwd_sel[2:0]);
        r_fwd1  = int'(fwd_sel[5:3]);
        r_pend  = int'(pending);
        check("issue_ready", r_ready, int'(rdy));
        check("fwd_sel0", r_fwd0, m_fwd(0));
        check("fwd_sel1", r_fwd1, m_fwd(1));
        check("pending", r_pend, m_pend());
        @(posedge clk);
        if (fl) model_clear();
        else begin
            for (int i = 0; i < 32; i++) begin
                if (wb_m[i] != 0) wb_m[i]--;
                if (bp_m[i] != 0) bp_m[i]--;
            end
            if (v && rdy && writes()) begin
                wb_m[dst] = int'(lat);
                bp_m[dst] = int'(byp);
            end
        end
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (6) step();
    endtask

    initial begin
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        step();
        check("reset_ready_lit", r_ready, 1);
        check("reset_pending_lit", r_pend, 0);
        check("reset_fwd_lit", r_fwd0 + r_fwd1, 0);

        // RAW: bypass not ready, then forward from stage wb_cnt
        idle(); v = 1; wen = 1; dst = 5; lat = 3; byp = 1; step();
        idle(); v = 1; src[0] = 5; en[0] = 1; step();
        check("raw_stall_lit", r_ready, 0);
        step();
        check("raw_ready_lit", r_ready, 1);
        check("raw_fwd_lit", r_fwd0, 2);
        drain();

        // WAW: long producer blocks a shorter one until it is nearly done
        idle(); v = 1; wen = 1; dst = 7; lat = 4; byp = 4; step();
        idle(); v = 1; wen = 1; dst = 7; lat = 1; byp = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("waw_stall_lit", r_ready, 0);
        end
        step();
        check("waw_release_lit", r_ready, 1);
        drain();

        // register zero is never tracked
        idle(); v = 1; wen = 1; dst = 0; lat = 2; en[0] = 1; en[1] = 1; step();
        check("r0_ready_lit", r_ready, 1);
        check("r0_fwd_lit", r_fwd0 + r_fwd1, 0);
        idle(); step();
        check("r0_pending_lit", r_pend, 0);

        // flush kills entries and the concurrent issue
        for (int d = 1; d <= 4; d++) begin
            idle(); v = 1; wen = 1; dst = 5'(d); lat = 4; byp = 2; step();
        end
        idle(); fl = 1; v = 1; wen = 1; dst = 10; lat = 4; byp = 0; step();
        check("flush_pending_before_lit", r_pend, 4);
        check("flush_ready_lit", r_ready, 0);
        idle(); src[0] = 1; en[0] = 1; src[1] = 10; en[1] = 1; step();
        check("flush_pending_lit", r_pend, 0);
        check("flush_fwd_lit", r_fwd0 + r_fwd1, 0);

        // re-issue on the last writeback cycle takes the new latency
        idle(); v = 1; wen = 1; dst = 9; lat = 2; byp = 0; step();
        idle(); step();
        idle(); v = 1; wen = 1; dst = 9; lat = 3; byp = 0; step();
        check("reissue_ready_lit", r_ready, 1);
        idle(); src[0] = 9; en[0] = 1; step();
        check("reissue_fwd_lit", r_fwd0, 3);
        check("reissue_pending_lit", r_pend, 1);
        drain();

        // asynchronous reset between clock edges
        idle(); v = 1; wen = 1; dst = 3; lat = 4; byp = 2; step();
        idle(); step();
        check("pre_reset_pending_lit", r_pend, 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_pending_lit", int'(pending), 0);
        model_clear();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(); src[0] = 3; en[0] = 1; step();
        check("post_reset_ready_lit", r_ready, 1);
        check("post_reset_pending_lit", r_pend, 0);

        // random traffic with a small register window to force hazards
        for (int n = 0; n < 3000; n++) begin
            v   = ($urandom % 4) != 0;
            wen = ($urandom % 4) != 0;
            dst = ($urandom % 3 == 0) ? 5'($urandom % 32) : 5'($urandom % 6);
            lat = 3'($urandom % 5);
            byp = 3'($urandom_range(0, int'(lat) + 1));
            for (int s = 0; s < 2; s++) begin
                src[s] = 5'($urandom % 6);
                en[s]  = ($urandom % 4) != 0;
            end
            fl = ($urandom % 50) == 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
